// File: rtl/conv_mac_seq.sv
// Serial signed fixed-point dot product of a latched D-element window and filter.
// Optional build macro CONV_RELU_EN clamps negative results to zero after saturation.
module conv_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 4,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [0:DATA_WIDTH*D-1]   image,
    input  logic [0:DATA_WIDTH*D-1]   filter,
    output logic                      busy,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      result_valid,
    input  logic                      result_ready
);

    // state | meaning
    // IDLE  | waiting for start; window and filter latched on acceptance
    // MAC   | one tap multiplied and accumulated per clock, taps 0..D-1
    // SCALE | accumulator shifted, saturated (and rectified) into result
    // OUT   | result held with result_valid until result_ready
    typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST_TAP = CW'(D - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    generate
        if (D < 1) begin : g_bad_d
            $error("conv_mac_seq: D must be >= 1");
        end
        if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(D)) begin : g_bad_acc
            $error("conv_mac_seq: ACC_WIDTH too small for D full-width products");
        end
    endgenerate

    state_t                        state, state_nxt;
    logic [CW-1:0]                 cnt;
    logic signed [DATA_WIDTH-1:0]  img_q [D];
    logic signed [DATA_WIDTH-1:0]  flt_q [D];
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc_shr;
    logic [DATA_WIDTH-1:0]         res_d;

    assign prod     = img_q[cnt] * flt_q[cnt];
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_shr  = acc >>> FRAC_BITS;

    always_comb begin
        res_d = acc_shr[DATA_WIDTH-1:0];
        if (acc_shr > SAT_MAX) begin
            res_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (acc_shr < SAT_MIN) begin
            res_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
`ifdef CONV_RELU_EN
        if (res_d[DATA_WIDTH-1]) begin
            res_d = '0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = MAC;
            MAC:   if (cnt == LAST_TAP) state_nxt = SCALE;
            SCALE: state_nxt = OUT;
            OUT:   if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            for (int i = 0; i < D; i++) begin
                img_q[i] <= '0;
                flt_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                        for (int i = 0; i < D; i++) begin
                            img_q[i] <= image[DATA_WIDTH*i +: DATA_WIDTH];
                            flt_q[i] <= filter[DATA_WIDTH*i +: DATA_WIDTH];
                        end
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    cnt <= (cnt == LAST_TAP) ? '0 : cnt + 1'b1;
                end
                SCALE: result <= res_d;
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == OUT);

endmodule

// File: tb/tb_conv_mac_seq.sv
// Randomised and directed bench for conv_mac_seq against an arithmetic dot-product model.
module tb_conv_mac_seq;

    localparam int DW   = 16;
    localparam int D    = 4;
    localparam int FRAC = 8;
    localparam int ACCW = 40;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [0:DW*D-1]   image = '0;
    logic [0:DW*D-1]   filter = '0;
    logic              busy;
    logic [DW-1:0]     result;
    logic              result_valid;
    logic              result_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    conv_mac_seq #(.DATA_WIDTH(DW), .D(D), .FRAC_BITS(FRAC), .ACC_WIDTH(ACCW)) dut (
        .clk(clk), .reset(reset), .start(start), .image(image), .filter(filter),
        .busy(busy), .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [0:DW*D-1] img, input logic [0:DW*D-1] flt);
        longint sum = 0;
        longint s;
        logic [DW-1:0] a, b;
        for (int i = 0; i < D; i++) begin
            a = img[DW*i +: DW];
            b = flt[DW*i +: DW];
            sum += longint'($signed(a)) * longint'($signed(b));
        end
        s = sum >>> FRAC;
        if (s > longint'(32767)) s = 32767;
        else if (s < longint'(-32768)) s = -32768;
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return DW'(s);
    endfunction

    function automatic logic [0:DW*D-1] rep(input logic [DW-1:0] v);
        return {D{v}};
    endfunction

    // Issues a window, checks latency and value, holds off ready for 'stall' cycles
    // (optionally pulsing an ignored start), then completes the handshake.
    task automatic run_window(input string tag, input logic [0:DW*D-1] img,
                              input logic [0:DW*D-1] flt, input int stall, input bit poke);
        logic [DW-1:0] exp;
        int n;
        exp = model(img, flt);
        image  = img;
        filter = flt;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        image  = {$urandom, $urandom};
        filter = {$urandom, $urandom};
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, n, D + 1);
        chk({tag, ".result"}, result, exp);
        for (int k = 0; k < stall; k++) begin
            if (poke && k == 1) begin
                start  = 1'b1;
                image  = rep(16'h0100);
                filter = rep(16'h0100);
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk({tag, ".hold_valid"}, result_valid, 1'b1);
            chk({tag, ".hold_result"}, result, exp);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({tag, ".valid_drop"}, result_valid, 1'b0);
        chk({tag, ".busy_drop"}, busy, 1'b0);
    endtask

    initial begin
        logic [0:DW*D-1] img1, flt1, ri, rf;
        img1 = rep(16'h0100);
        flt1 = {16'h0100, 16'h0200, 16'h0300, 16'h0400};

        #12;
        chk("rst.busy", busy, 1'b0);
        chk("rst.valid", result_valid, 1'b0);
        chk("rst.result", result, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_window("t1", img1, flt1, 0, 0);
        chk("t1.value", result, 16'h0A00);
        @(posedge clk); #1;

        run_window("t2a", rep(16'h7FFF), rep(16'h7FFF), 0, 0);
        chk("t2a.value", result, 16'h7FFF);
        run_window("t2b", rep(16'h7FFF), rep(16'h8000), 0, 0);
`ifdef CONV_RELU_EN
        chk("t2b.value", result, 16'h0000);
`else
        chk("t2b.value", result, 16'h8000);
`endif
        run_window("t3a", rep(16'hFFFF), rep(16'h0001), 0, 0);
`ifdef CONV_RELU_EN
        chk("t3a.value", result, 16'h0000);
`else
        chk("t3a.value", result, 16'hFFFF);
`endif
        run_window("t3b", rep(16'h0001), rep(16'h0001), 0, 0);
        chk("t3b.value", result, 16'h0000);

        run_window("t4", rep(16'hFF00), rep(16'h0100), 3, 1);
`ifdef CONV_RELU_EN
        chk("t4.value", result, 16'h0000);
`else
        chk("t4.value", result, 16'hFC00);
`endif
        @(posedge clk); #1;
        chk("t4.no_restart", busy, 1'b0);

        image  = img1;
        filter = flt1;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("t5.busy", busy, 1'b0);
        chk("t5.valid", result_valid, 1'b0);
        chk("t5.result", result, 16'h0000);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        run_window("t5r", img1, flt1, 0, 0);
        chk("t5r.value", result, 16'h0A00);

        run_window("t6a", img1, flt1, 0, 0);
        run_window("t6b", rep(16'h0100), rep(16'h0100), 0, 0);
        chk("t6b.value", result, 16'h0400);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < D; i++) begin
                if (r % 3 == 0) begin
                    ri[DW*i +: DW] = DW'($urandom);
                    rf[DW*i +: DW] = DW'($urandom);
                end else begin
                    ri[DW*i +: DW] = DW'($signed($urandom_range(0, 2047)) - 1024);
                    rf[DW*i +: DW] = DW'($signed($urandom_range(0, 2047)) - 1024);
                end
            end
            run_window("rnd", ri, rf, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
